// File: rtl/framebuffer_axis_writer_pkg.sv
// Shared definitions for the framebuffer AXI-stream writer: AXI burst and
// response encodings, the default AW cache attribute, and the FSM state type.
package framebuffer_axis_writer_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } fbw_state_e;

endpackage

// File: rtl/framebuffer_axis_writer_if.sv
// Bus bundle for the framebuffer writer: the incoming framebuffer AXI stream
// plus the AW/W/B channels of the write-only AXI4 initiator.
//   master : the writer side (consumes the stream, drives AW/W, accepts B)
//   slave  : the environment side (stream source and memory target)
interface framebuffer_axis_writer_if
  import framebuffer_axis_writer_pkg::*;
#(
  parameter int unsigned STREAM_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned ID_WIDTH     = 8
);

  // Framebuffer stream
  logic                      s_axis_tvalid;
  logic                      s_axis_tready;
  logic                      s_axis_tlast;
  logic [STREAM_WIDTH-1:0]   s_axis_tdata;

  // AXI write address
  logic [ID_WIDTH-1:0]       m_axi_awid;
  logic [ADDR_WIDTH-1:0]     m_axi_awaddr;
  logic [7:0]                m_axi_awlen;
  logic [2:0]                m_axi_awsize;
  logic [1:0]                m_axi_awburst;
  logic                      m_axi_awlock;
  logic [3:0]                m_axi_awcache;
  logic [2:0]                m_axi_awprot;
  logic                      m_axi_awvalid;
  logic                      m_axi_awready;

  // AXI write data
  logic [STREAM_WIDTH-1:0]   m_axi_wdata;
  logic [STREAM_WIDTH/8-1:0] m_axi_wstrb;
  logic                      m_axi_wlast;
  logic                      m_axi_wvalid;
  logic                      m_axi_wready;

  // AXI write response
  logic [ID_WIDTH-1:0]       m_axi_bid;
  logic [1:0]                m_axi_bresp;
  logic                      m_axi_bvalid;
  logic                      m_axi_bready;

  modport master (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata,
    output s_axis_tready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata,
    input  s_axis_tready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/framebuffer_axis_writer.sv
// Writes one frame of framebuffer stream beats into AXI memory as INCR bursts
// starting at a burst-aligned base address. One outstanding burst at a time.
//   aclk, rst          : clock, asynchronous active-high reset
//   start              : one-cycle frame request (ignored while busy)
//   base_addr          : frame byte address, low burst-size bits forced to 0
//   frame_beats        : frame length in beats (0 completes immediately)
//   busy / done        : frame in progress / one-cycle completion pulse
//   err_tlast          : sticky, tlast seen away from the frame's final beat
//   err_resp           : sticky, non-OKAY write response seen
//   bus (master)       : framebuffer stream in, AXI AW/W/B out
module framebuffer_axis_writer
  import framebuffer_axis_writer_pkg::*;
#(
  parameter int unsigned STREAM_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned BURST_BEATS  = 16,
  parameter int unsigned BEATS_WIDTH  = 20
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [BEATS_WIDTH-1:0] frame_beats,
  output logic                   busy,
  output logic                   done,
  output logic                   err_tlast,
  output logic                   err_resp,
  framebuffer_axis_writer_if.master bus
);

  localparam int unsigned BYTES_PER_BEAT = STREAM_WIDTH / 8;
  localparam int unsigned SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
  localparam int unsigned ALIGN_BITS     = $clog2(BURST_BEATS * BYTES_PER_BEAT);
  localparam logic [ADDR_WIDTH-1:0]  ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));
  localparam logic [BEATS_WIDTH-1:0] MAX_BURST = BEATS_WIDTH'(BURST_BEATS);

  // awlen for a burst covering min(rem, BURST_BEATS) beats
  function automatic logic [7:0] burst_awlen(input logic [BEATS_WIDTH-1:0] rem);
    logic [BEATS_WIDTH-1:0] len;
    len = (rem > MAX_BURST) ? MAX_BURST : rem;
    return 8'(len - BEATS_WIDTH'(1));
  endfunction

  fbw_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]             awlen_q, awlen_d;
  logic [BEATS_WIDTH-1:0] rem_q, rem_d;
  logic [7:0]             beat_q, beat_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_tlast_q, err_tlast_d;
  logic                   err_resp_q, err_resp_d;

  logic                   aw_hs, w_hs, b_hs;
  logic [8:0]             burst_beats;
  logic [BEATS_WIDTH-1:0] rem_after_burst;
  logic [ADDR_WIDTH-1:0]  addr_after_burst;
  logic                   last_in_burst;
  logic                   final_beat;

  assign aw_hs = (state_q == ST_ADDR) && bus.m_axi_awready;
  assign w_hs  = (state_q == ST_DATA) && bus.s_axis_tvalid && bus.m_axi_wready;
  assign b_hs  = (state_q == ST_RESP) && bus.m_axi_bvalid;

  assign burst_beats      = {1'b0, awlen_q} + 9'd1;
  assign rem_after_burst  = rem_q - BEATS_WIDTH'(burst_beats);
  assign addr_after_burst = addr_q + (ADDR_WIDTH'(burst_beats) << SIZE_LOG2);
  assign last_in_burst    = (beat_q == awlen_q);
  // The frame's last beat is the last beat of the burst that exhausts rem_q
  assign final_beat       = last_in_burst && (rem_q == BEATS_WIDTH'(burst_beats));

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      awlen_q     <= '0;
      rem_q       <= '0;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_tlast_q <= 1'b0;
      err_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      awlen_q     <= awlen_d;
      rem_q       <= rem_d;
      beat_q      <= beat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_tlast_q <= err_tlast_d;
      err_resp_q  <= err_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    awlen_d     = awlen_q;
    rem_d       = rem_q;
    beat_d      = beat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_tlast_d = err_tlast_q;
    err_resp_d  = err_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr & ALIGN_MASK;
          rem_d       = frame_beats;
          err_tlast_d = 1'b0;
          err_resp_d  = 1'b0;
          if (frame_beats == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            awlen_d = burst_awlen(frame_beats);
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (bus.s_axis_tlast != final_beat) begin
            err_tlast_d = 1'b1;
          end
          if (last_in_burst) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          if (bus.m_axi_bresp != AXI_RESP_OKAY) begin
            err_resp_d = 1'b1;
          end
          rem_d  = rem_after_burst;
          addr_d = addr_after_burst;
          if (rem_after_burst == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            awlen_d = burst_awlen(rem_after_burst);
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_tlast = err_tlast_q;
  assign err_resp  = err_resp_q;

  assign bus.m_axi_awid    = ID_WIDTH'(0);
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = 3'(SIZE_LOG2);
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = AXI_CACHE_DEFAULT;
  assign bus.m_axi_awprot  = AXI_PROT_DEFAULT;
  assign bus.m_axi_awvalid = (state_q == ST_ADDR);

  // Stream is passed straight through to W; only the valid/ready pair is gated
  assign bus.m_axi_wdata   = bus.s_axis_tdata;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wvalid  = (state_q == ST_DATA) && bus.s_axis_tvalid;
  assign bus.m_axi_wlast   = (state_q == ST_DATA) && last_in_burst;
  assign bus.s_axis_tready = (state_q == ST_DATA) && bus.m_axi_wready;

  assign bus.m_axi_bready  = (state_q == ST_RESP);

endmodule

// File: tb/tb_framebuffer_axis_writer.sv
module tb_framebuffer_axis_writer;
  import framebuffer_axis_writer_pkg::*;

  localparam int SW = 64;
  localparam int AW = 24;
  localparam int IW = 8;
  localparam int BB = 16;
  localparam int BW = 20;
  localparam logic [AW-1:0] ALIGN_LOW = AW'(BB * SW / 8 - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [BW-1:0] frame_beats;
  logic          busy, done, err_tlast, err_resp;

  framebuffer_axis_writer_if #(.STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  framebuffer_axis_writer #(
    .STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_BEATS(BB), .BEATS_WIDTH(BW)
  ) dut (
    .aclk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_beats(frame_beats),
    .busy(busy), .done(done), .err_tlast(err_tlast), .err_resp(err_resp), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [AW-1:0] addr; logic [SW-1:0] data; logic last; } w_t;
  typedef struct { logic [SW-1:0] data; logic last; } s_t;
  typedef struct {
    logic [AW-1:0] base; int beats; bit stall; int tlast_extra; bit drop_final;
    int err_burst; bit poke; bit exp_err_tlast; bit exp_err_resp; int exp_bursts;
  } vec_t;

  int  n_checks = 0;
  int  n_pass   = 0;
  aw_t exp_aw[$];
  w_t  exp_w[$];
  s_t  stream_q[$];
  bit  stall_en = 1'b0;
  int  err_burst = -1;
  int  burst_idx = 0;
  int  b_pending = 0;
  int  aw_cnt = 0, w_cnt = 0, done_cnt = 0;
  logic [AW-1:0] cur_aw_addr = '0;
  int  w_beat = 0;
  bit  aw_held = 1'b0;
  aw_t held;
  bit  prev_b_hs = 1'b0, prev_b_last = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endfunction

  // Expected AW/W traffic and the stream beats that feed it
  task automatic build_expect(input logic [AW-1:0] base, input int beats,
                              input int tl_extra, input bit drop_final);
    logic [AW-1:0] addr;
    int rem, len, i;
    aw_t a; w_t w; s_t s;
    addr = base & ~ALIGN_LOW;
    rem  = beats;
    i    = 0;
    while (rem > 0) begin
      len    = (rem > BB) ? BB : rem;
      a.addr = addr;
      a.len  = 8'(len - 1);
      exp_aw.push_back(a);
      for (int k = 0; k < len; k++) begin
        s.data = {$urandom, $urandom};
        s.last = (i == beats - 1) ? !drop_final : (i == tl_extra);
        stream_q.push_back(s);
        w.addr = addr + AW'(k * (SW / 8));
        w.data = s.data;
        w.last = (k == len - 1);
        exp_w.push_back(w);
        i++;
      end
      addr = addr + AW'(len * (SW / 8));
      rem  = rem - len;
    end
  endtask

  // Stream source + memory target model; drives at negedge, evaluates the
  // handshakes that will commit at the following posedge.
  initial begin
    aw_t e; w_t ew; logic [AW-1:0] wa;
    bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0;
    bus.m_axi_bresp = 0; bus.m_axi_bid = '0;
    bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.s_axis_tdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0;
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0;
        b_pending = 0; aw_held = 0; prev_b_hs = 0; w_beat = 0;
      end else begin
        bus.m_axi_awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.m_axi_wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (stream_q.size() > 0) begin
          bus.s_axis_tvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
          bus.s_axis_tdata  = stream_q[0].data;
          bus.s_axis_tlast  = stream_q[0].last;
        end else begin
          bus.s_axis_tvalid = 1'b0;
        end
        bus.m_axi_bvalid = (b_pending > 0) && (stall_en ? ($urandom_range(0, 1) != 0) : 1'b1);
        bus.m_axi_bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
        #1;
        if (prev_b_hs) begin
          if (prev_b_last) begin
            chk("done_after_b", done, 1);
            chk("busy_after_b", busy, 0);
          end else begin
            chk("awvalid_after_b", bus.m_axi_awvalid, 1);
          end
          prev_b_hs = 0;
        end
        if (done) done_cnt++;
        if (!busy)
          chk("idle_quiet", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.s_axis_tready, bus.m_axi_bready}, 0);
        if (aw_held)
          chk("aw_stable", {bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen}, {1'b1, held.addr, held.len});
        aw_held   = bus.m_axi_awvalid && !bus.m_axi_awready;
        held.addr = bus.m_axi_awaddr;
        held.len  = bus.m_axi_awlen;
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          aw_cnt++;
          if (exp_aw.size() == 0) chk("unexpected_aw", bus.m_axi_awaddr, 64'hDEAD);
          else begin
            e = exp_aw.pop_front();
            chk("awaddr", bus.m_axi_awaddr, e.addr);
            chk("awlen", bus.m_axi_awlen, e.len);
            chk("aw_const", {bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awlock,
                             bus.m_axi_awcache, bus.m_axi_awprot}, {8'h00, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000});
          end
          cur_aw_addr = bus.m_axi_awaddr;
          w_beat = 0;
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          w_cnt++;
          if (stream_q.size() > 0) void'(stream_q.pop_front());
          wa = cur_aw_addr + AW'(w_beat * (SW / 8));
          w_beat++;
          if (exp_w.size() == 0) chk("unexpected_w", bus.m_axi_wdata, 64'hDEAD);
          else begin
            ew = exp_w.pop_front();
            chk("w_addr", wa, ew.addr);
            chk("wdata", bus.m_axi_wdata, ew.data);
            chk("wlast", bus.m_axi_wlast, ew.last);
            chk("wstrb", bus.m_axi_wstrb, 8'hFF);
          end
          if (bus.m_axi_wlast) b_pending++;
        end
        if (bus.m_axi_bvalid && bus.m_axi_bready) begin
          b_pending--;
          burst_idx++;
          prev_b_hs   = 1;
          prev_b_last = (exp_aw.size() == 0);
        end
      end
    end
  end

  task automatic run_frame(input vec_t v);
    int aw0, w0, d0, n;
    aw0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
    @(negedge clk);
    stall_en  = v.stall;
    err_burst = v.err_burst;
    burst_idx = 0;
    build_expect(v.base, v.beats, v.tlast_extra, v.drop_final);
    base_addr   = v.base;
    frame_beats = BW'(v.beats);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    if (v.beats == 0) chk("done_at_n1", done, 1);
    else chk("awvalid_at_n1", bus.m_axi_awvalid, 1);
    chk("err_cleared_on_start", {err_tlast, err_resp}, 0);
    if (v.poke) begin
      repeat (2) @(negedge clk);
      #2;
      chk("busy_at_poke", busy, 1);
      base_addr   = '0;
      frame_beats = BW'(5);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    repeat (3) @(negedge clk);
    #2;
    chk("done_pulses", done_cnt - d0, 1);
    chk("done_low", done, 0);
    chk("busy_end", busy, 0);
    chk("err_tlast", err_tlast, v.exp_err_tlast);
    chk("err_resp", err_resp, v.exp_err_resp);
    chk("aw_count", aw_cnt - aw0, v.exp_bursts);
    chk("w_count", w_cnt - w0, v.beats);
    chk("queues_drained", {exp_aw.size() != 0, exp_w.size() != 0, stream_q.size() != 0}, 0);
    exp_aw.delete(); exp_w.delete(); stream_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    //            base          beats stall tl_x drop errb poke e_tl e_rs bursts
    vecs[0] = '{24'h001000,  40, 1'b0,  -1, 1'b0,  -1, 1'b0, 1'b0, 1'b0, 3};
    vecs[1] = '{24'h002345, 100, 1'b1,  -1, 1'b0,  -1, 1'b0, 1'b0, 1'b0, 7};
    vecs[2] = '{24'h000500,   0, 1'b0,  -1, 1'b0,  -1, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{24'h004000,  16, 1'b0,   5, 1'b1,  -1, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{24'h001000,  40, 1'b0,  -1, 1'b0,   1, 1'b0, 1'b0, 1'b1, 3};
    vecs[5] = '{24'h008000,  17, 1'b1,  -1, 1'b0,  -1, 1'b1, 1'b0, 1'b0, 2};
    vecs[6] = '{24'hFFFF80,  32, 1'b0,  -1, 1'b0,  -1, 1'b0, 1'b0, 1'b0, 2};

    rst = 1'b1; start = 1'b0; base_addr = '0; frame_beats = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_status", {busy, done, err_tlast, err_resp}, 0);
    chk("rst_awvalid", bus.m_axi_awvalid, 0);
    chk("rst_wvalid", bus.m_axi_wvalid, 0);
    chk("rst_wlast", bus.m_axi_wlast, 0);
    chk("rst_bready", bus.m_axi_bready, 0);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_aw_fields", {bus.m_axi_awaddr, bus.m_axi_awlen}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset in the middle of a frame's data phase
    @(negedge clk);
    stall_en = 1'b0; err_burst = -1; burst_idx = 0;
    build_expect(24'h006000, 40, -1, 1'b0);
    base_addr = 24'h006000; frame_beats = BW'(40); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("mid_data_wvalid", bus.m_axi_wvalid, 1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("abort_status", {busy, done, err_tlast, err_resp}, 0);
    chk("abort_handshakes", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast,
                             bus.m_axi_bready, bus.s_axis_tready}, 0);
    chk("abort_aw_fields", {bus.m_axi_awaddr, bus.m_axi_awlen}, 0);
    exp_aw.delete(); exp_w.delete(); stream_q.delete();
    @(negedge clk);
    rst = 1'b0;
    v = '{24'h003000, 24, 1'b0, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 2};
    run_frame(v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
